// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_rd_packer_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int MAX_WORD_W         = 512;

  // Little-endian placement: entry lands in bits [slot*width +: width] of word.
  function automatic logic [MAX_WORD_W-1:0] place_slot(
    input logic [MAX_WORD_W-1:0] word,
    input logic [MAX_WORD_W-1:0] entry,
    input int unsigned           slot,
    input int unsigned           width
  );
    logic [MAX_WORD_W-1:0] mask;
    mask = {MAX_WORD_W{1'b1}} >> (MAX_WORD_W - width);
    return (word & ~(mask << (slot * width))) | ((entry & mask) << (slot * width));
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-word valid/ready stream seen by the packer.
interface fifo_rd_packer_if
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_WIDTH      = 4
);
  logic [WIDTH-1:0]                fifo_data;
  logic                            fifo_empty;
  logic                            fifo_get;
  logic                            flush;
  logic [WIDTH*BYTES_PER_WORD-1:0] out_data;
  logic [CNT_WIDTH-1:0]            out_bytes;
  logic                            out_valid;
  logic                            out_ready;
  logic                            busy;

  modport master (
    input  fifo_data, fifo_empty, flush, out_ready,
    output fifo_get, out_data, out_bytes, out_valid, busy
  );

  modport slave (
    output fifo_data, fifo_empty, flush, out_ready,
    input  fifo_get, out_data, out_bytes, out_valid, busy
  );
endinterface

// File: rtl/fifo_rd_word_reg.sv
// Output word register: loads a packed word and holds it until the handshake.
module fifo_rd_word_reg #(
  parameter int WORD_W    = 32,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WORD_W-1:0]    load_data,
  input  logic [CNT_WIDTH-1:0] load_bytes,
  input  logic                 ready,
  output logic [WORD_W-1:0]    data,
  output logic [CNT_WIDTH-1:0] bytes,
  output logic                 valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      bytes <= '0;
      valid <= 1'b0;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end else if (load && !valid) begin
      data  <= load_data;
      bytes <= load_bytes;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries, packs BYTES_PER_WORD of them little-endian into one word,
// and emits full or flushed partial words over valid/ready.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_WIDTH      = 4
) (
  input logic              rclk,
  input logic              reset,
  fifo_rd_packer_if.master bus
);

  localparam int WORD_W = WIDTH * BYTES_PER_WORD;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(BYTES_PER_WORD);

  state_t               state;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] captured;
  logic                 vld_p1;
  logic                 flush_pending;
  logic [WORD_W-1:0]    pack;

  logic [WORD_W-1:0]    pack_nxt;
  logic [CNT_WIDTH-1:0] captured_nxt;
  logic                 get;
  logic                 handshake;
  logic                 word_full;
  logic                 flush_emit;
  logic                 flush_drop;
  logic                 load;

  always_comb begin
    get          = !reset && !bus.fifo_empty && !bus.out_valid && !flush_pending &&
                   (issued < FULL_CNT);
    handshake    = bus.out_valid && bus.out_ready;
    pack_nxt     = pack;
    captured_nxt = captured;
    // capture stage: the entry popped last cycle lands in slot[captured]
    if (vld_p1) begin
      pack_nxt     = WORD_W'(place_slot(MAX_WORD_W'(pack), MAX_WORD_W'(bus.fifo_data),
                                        32'(captured), 32'(WIDTH)));
      captured_nxt = captured + CNT_WIDTH'(1);
    end
    word_full  = vld_p1 && (captured_nxt == FULL_CNT);
    flush_emit = flush_pending && !vld_p1 && (captured != '0) && !bus.out_valid;
    flush_drop = flush_pending && !vld_p1 && (captured == '0) && !bus.out_valid;
    load       = word_full || flush_emit;
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state         <= FILL;
      issued        <= '0;
      captured      <= '0;
      vld_p1        <= 1'b0;
      flush_pending <= 1'b0;
      pack          <= '0;
    end else if (handshake) begin
      issued        <= '0;
      captured      <= '0;
      vld_p1        <= 1'b0;
      pack          <= '0;
      flush_pending <= flush_pending || bus.flush;
      state         <= (flush_pending || bus.flush) ? DRAIN : FILL;
    end else begin
      issued   <= issued + CNT_WIDTH'(get);
      vld_p1   <= get;
      captured <= captured_nxt;
      pack     <= pack_nxt;
      // Any emitted word satisfies a pending or simultaneous flush.
      if (load || flush_drop) flush_pending <= 1'b0;
      else                    flush_pending <= flush_pending || bus.flush;
      case (state)
        FILL:    if (load) state <= HOLD;
                 else if (bus.flush) state <= DRAIN;
        DRAIN:   if (load) state <= HOLD;
                 else if (flush_drop) state <= FILL;
        HOLD:    state <= HOLD;
        default: state <= FILL;
      endcase
    end
  end

  fifo_rd_word_reg #(
    .WORD_W    (WORD_W),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_word_reg (
    .clk        (rclk),
    .rst        (reset),
    .load       (load),
    .load_data  (pack_nxt),
    .load_bytes (captured_nxt),
    .ready      (bus.out_ready),
    .data       (bus.out_data),
    .bytes      (bus.out_bytes),
    .valid      (bus.out_valid)
  );

  assign bus.fifo_get = get;
  assign bus.busy     = (captured != '0) || vld_p1 || bus.out_valid || flush_pending;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model, word scoreboard, vector table and corner sequences.
module tb_fifo_rd_packer;
  import fifo_rd_packer_pkg::*;

  localparam int WIDTH = 8;
  localparam int BPW   = 4;
  localparam int CW    = 4;

  logic rclk = 1'b0;
  logic reset;
  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.WIDTH(WIDTH), .BYTES_PER_WORD(BPW), .CNT_WIDTH(CW)) bus ();

  fifo_rd_packer #(.WIDTH(WIDTH), .BYTES_PER_WORD(BPW), .CNT_WIDTH(CW)) dut (
    .rclk  (rclk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  bytes;
  } word_t;

  typedef struct {
    int          n;
    logic [31:0] ents;       // first entry in the top byte
    logic        use_flush;
    logic [31:0] exp_data;
    logic [3:0]  exp_bytes;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int words_seen = 0;
  logic [7:0] fq[$];
  word_t exp_q[$];

  logic        s_valid, s_ready, s_get, s_busy, s_reset;
  logic [31:0] s_data;
  logic [3:0]  s_bytes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] n);
    word_t w;
    w.data  = d;
    w.bytes = n;
    exp_q.push_back(w);
  endtask

  // One clock: sample at negedge, model the FIFO pop and score handshakes after posedge.
  task automatic tick();
    logic  popped;
    word_t w;
    @(negedge rclk);
    popped  = bus.fifo_get;
    s_get   = bus.fifo_get;
    s_valid = bus.out_valid;
    s_ready = bus.out_ready;
    s_data  = bus.out_data;
    s_bytes = bus.out_bytes;
    s_busy  = bus.busy;
    s_reset = reset;
    @(posedge rclk);
    #1;
    if (popped && fq.size() > 0) bus.fifo_data = fq.pop_front();
    bus.fifo_empty = (fq.size() == 0);
    if (s_valid && s_ready && !s_reset) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got %h/%0d, want no word", s_data, s_bytes);
      end else begin
        w = exp_q.pop_front();
        check("word_data", s_data, w.data);
        check("word_bytes", 32'(s_bytes), 32'(w.bytes));
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_timeout_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    fq.delete();
    exp_q.delete();
    bus.fifo_empty = 1'b1;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t vt[6];

  initial begin
    logic [6:0]  gets, vals;
    logic [31:0] ents;
    int          bad, w0;

    reset          = 1'b1;
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;

    vt[0] = '{4, 32'h11223344, 1'b0, 32'h44332211, 4'd4};
    vt[1] = '{4, 32'hDEADBEEF, 1'b0, 32'hEFBEADDE, 4'd4};
    vt[2] = '{2, 32'hAABB0000, 1'b1, 32'h0000BBAA, 4'd2};
    vt[3] = '{1, 32'h5A000000, 1'b1, 32'h0000005A, 4'd1};
    vt[4] = '{3, 32'h01020300, 1'b1, 32'h00030201, 4'd3};
    vt[5] = '{4, 32'h00FF807F, 1'b0, 32'h7F80FF00, 4'd4};

    do_reset();
    check("rst_fifo_get", 32'(bus.fifo_get), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_bytes", 32'(bus.out_bytes), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Pop latency and word timing
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_word(32'h44332211, 4'd4);
    gets = '0;
    vals = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      gets[i] = s_get;
      vals[i] = s_valid;
      if (i == 5) begin
        check("lat_out_data", s_data, 32'h44332211);
        check("lat_out_bytes", 32'(s_bytes), 32'd4);
      end
    end
    check("lat_get_pattern", 32'(gets), 32'(7'b0001111));
    check("lat_valid_pattern", 32'(vals), 32'(7'b0100000));
    wait_drain(5);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      ents = vt[v].ents;
      for (int i = 0; i < vt[v].n; i++) push(ents[31-8*i -: 8]);
      expect_word(vt[v].exp_data, vt[v].exp_bytes);
      if (vt[v].use_flush) begin
        for (int k = 0; k < 6; k++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
      end
      wait_drain(20);
      tick();
      check($sformatf("vec%0d_busy_after", v), 32'(bus.busy), 32'd0);
    end

    // Downstream stall holds the word and blocks pops
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    expect_word(32'h04030201, 4'd4);
    expect_word(32'h08070605, 4'd4);
    for (int i = 0; i < 6; i++) tick();
    check("stall_first_valid", 32'(bus.out_valid), 32'd1);
    check("stall_first_data", bus.out_data, 32'h04030201);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_data !== 32'h04030201 || s_valid !== 1'b1 || s_get !== 1'b0) bad++;
    end
    check("stall_hold_violations", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    wait_drain(30);

    // Flush with nothing captured or in flight
    w0 = words_seen;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("idle_flush_pending_busy", 32'(bus.busy), 32'd1);
    tick();
    check("idle_flush_pending_clear", 32'(bus.busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_valid || s_get) bad++;
    end
    check("idle_flush_no_activity", 32'(bad), 32'd0);
    check("idle_flush_words", 32'(words_seen - w0), 32'd0);

    // Flush coincident with the final capture
    w0 = words_seen;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_word(32'h44332211, 4'd4);
    for (int i = 0; i < 4; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("flush_last_words", 32'(words_seen - w0), 32'd1);
    check("flush_last_exp_left", 32'(exp_q.size()), 32'd0);
    check("flush_last_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();

    // Reset in the cycle after the second accepted pop
    w0 = words_seen;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    tick();
    tick();
    reset = 1'b1;
    fq.delete();
    bus.fifo_empty = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_fifo_get", 32'(bus.fifo_get), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", bus.out_data, 32'd0);
    check("midrst_out_bytes", 32'(bus.out_bytes), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    expect_word(32'h88776655, 4'd4);
    wait_drain(20);
    check("midrst_words", 32'(words_seen - w0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
